// File: rtl/rv32i_alu_pkg.sv
// Shared RV32I datapath types: machine word and ALU operation encoding.
package rv32i_types;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] rv32i_word;

  // Encoding is fixed by the decoder and must not be reordered.
  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

endpackage

// File: rtl/rv32i_alu_shifter.sv
// Barrel shifter for the execute stage: left logical, right logical or right arithmetic.
module rv32i_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   shamt,
  input  logic             left,
  input  logic             arith,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    if (left) begin
      result = data << shamt;
    end else if (arith) begin
      result = $signed(data) >>> shamt;
    end else begin
      result = data >> shamt;
    end
  end

endmodule

// File: rtl/rv32i_alu.sv
// RV32I execute-stage ALU: combinational result f plus an enabled pipeline register f_q.
module rv32i_alu
  import rv32i_types::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  alu_ops           aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] f_q
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] shift_result;
  logic             shift_left;
  logic             shift_arith;

  assign shift_left  = (aluop == alu_sll);
  assign shift_arith = (aluop == alu_sra);

  // Only the low shift-amount bits of b steer the shifter; upper bits are ignored.
  rv32i_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shifter (
    .data   (a),
    .shamt  (b[SHW-1:0]),
    .left   (shift_left),
    .arith  (shift_arith),
    .result (shift_result)
  );

  always_comb begin
    f = '0;
    case (aluop)
      alu_add: f = a + b;
      alu_sll: f = shift_result;
      alu_sra: f = shift_result;
      alu_sub: f = a - b;
      alu_xor: f = a ^ b;
      alu_srl: f = shift_result;
      alu_or:  f = a | b;
      alu_and: f = a & b;
      // Reached only when aluop is X/Z in simulation; forces a clean zero.
      default: f = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q <= '0;
    end else if (en) begin
      f_q <= f;
    end
  end

endmodule

// File: tb/tb_rv32i_alu.sv
// Directed and randomized checks of rv32i_alu against hand-computed values and a reference model.
module tb_rv32i_alu;
  import rv32i_types::*;

  logic        clk;
  logic        rst_n;
  alu_ops      aluop;
  logic [31:0] a;
  logic [31:0] b;
  logic        en;
  logic [31:0] f;
  logic [31:0] f_q;

  int n_tests = 0;
  int n_fail  = 0;

  rv32i_alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .aluop (aluop),
    .a     (a),
    .b     (b),
    .en    (en),
    .f     (f),
    .f_q   (f_q)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic drive(input alu_ops op, input logic [31:0] va, input logic [31:0] vb);
    aluop = op;
    a     = va;
    b     = vb;
    #1;
  endtask

  // reference model written from the operation equations
  function automatic logic [31:0] model(input alu_ops op, input logic [31:0] va, input logic [31:0] vb);
    logic [31:0] ones;
    logic [4:0]  s;
    logic [31:0] r;
    ones = 32'hFFFF_FFFF;
    s    = vb[4:0];
    r    = 32'h0;
    case (op)
      alu_add: r = va + vb;
      alu_sub: r = va + ~vb + 32'd1;
      alu_sll: r = va << s;
      alu_srl: r = va >> s;
      alu_sra: begin
        r = va >> s;
        if (va[31]) r = r | ~(ones >> s);
      end
      alu_xor: r = va ^ vb;
      alu_or:  r = va | vb;
      alu_and: r = va & vb;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  initial begin
    logic        f_x_seen;
    alu_ops      rop;
    logic [31:0] ra;
    logic [31:0] rb;

    rst_n = 1'b0;
    en    = 1'b0;
    aluop = alu_add;
    a     = 32'h0;
    b     = 32'h0;
    #2;
    check("reset_f_q", f_q, 32'h0);

    // combinational vectors
    drive(alu_add, 32'hFFFF_FFFF, 32'h1);        check("add_wrap", f, 32'h0);
    drive(alu_sub, 32'h0, 32'h1);                check("sub_wrap", f, 32'hFFFF_FFFF);
    drive(alu_sub, 32'h5, 32'h3);                check("sub_5_3", f, 32'h2);
    drive(alu_sll, 32'h1, 32'd31);               check("sll_31", f, 32'h8000_0000);
    drive(alu_srl, 32'h8000_0000, 32'd4);        check("srl_4", f, 32'h0800_0000);
    drive(alu_sra, 32'h8000_0000, 32'd4);        check("sra_neg_4", f, 32'hF800_0000);
    drive(alu_sra, 32'h7FFF_FFF0, 32'd4);        check("sra_pos_4", f, 32'h07FF_FFFF);
    drive(alu_sll, 32'h1, 32'h0000_0021);        check("sll_mask", f, 32'h2);
    drive(alu_srl, 32'hDEAD_BEEF, 32'h0);        check("srl_zero", f, 32'hDEAD_BEEF);
    drive(alu_sra, 32'h8000_0001, 32'hFFFF_FFE0); check("sra_mask_zero", f, 32'h8000_0001);
    drive(alu_sra, 32'h8000_0000, 32'd31);       check("sra_31", f, 32'hFFFF_FFFF);
    drive(alu_xor, 32'hF0F0_F0F0, 32'hFF00_FF00); check("xor", f, 32'h0FF0_0FF0);
    drive(alu_or,  32'hF0F0_F0F0, 32'hFF00_FF00); check("or", f, 32'hFFF0_FFF0);
    drive(alu_and, 32'hF0F0_F0F0, 32'hFF00_FF00); check("and", f, 32'hF000_F000);
    check("f_q_held_in_reset", f_q, 32'h0);

    // register path
    @(negedge clk);
    rst_n = 1'b1;
    aluop = alu_add;
    a     = 32'd2;
    b     = 32'd3;
    en    = 1'b1;
    @(posedge clk); #1;
    check("f_q_load", f_q, 32'd5);
    en = 1'b0;
    a  = 32'd7;
    b  = 32'd9;
    @(posedge clk); #1;
    check("f_q_hold", f_q, 32'd5);
    check("f_tracks_when_held", f, 32'd16);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("f_q_async_clear", f_q, 32'h0);
    check("f_during_reset", f, 32'd16);
    @(negedge clk);
    rst_n = 1'b1;
    aluop = alu_sub;
    a     = 32'd5;
    b     = 32'd3;
    en    = 1'b1;
    @(posedge clk); #1;
    check("f_q_first_after_reset", f_q, 32'd2);
    en = 1'b0;

    // random sweep against the model
    f_x_seen = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      rop = alu_ops'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      drive(rop, ra, rb);
      if ($isunknown(f)) f_x_seen = 1'b1;
      check($sformatf("rand_%0d_op%0d", i, rop), f, model(rop, ra, rb));
    end
    check("f_never_x", {31'h0, f_x_seen}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no_finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rv32i_alu.md
# rv32i_alu

Integer arithmetic/logic unit for the RV32I pipeline's execute stage. It computes one of eight 32-bit operations on operands `a` and `b`, selected by `aluop`. The result is available combinationally on `f` in the same cycle and is also captured into a pipeline-visible register `f_q`. The execute stage drives `a` and `b` from its operand muxes (forwarded rs1 or PC; forwarded rs2 or an immediate).

## Interface
- `WIDTH` — default 32 — datapath width; only 32 is required to work.
- `clk` — in — 1 — system clock; `f_q` updates on the rising edge.
- `rst_n` — in — 1 — asynchronous, active-low reset.
- `aluop` — in — 3 (`alu_ops`) — operation select.
- `a` — in — WIDTH — operand A.
- `b` — in — WIDTH — operand B; for shifts, only `b[4:0]` is used.
- `en` — in — 1 — when high, `f_q` captures `f` at the clock edge.
- `f` — out — WIDTH — combinational result.
- `f_q` — out — WIDTH — registered result.

## Operation
`alu_ops` encoding:
- 000 `alu_add`: `f = a + b`, modulo 2^32; carry discarded.
- 001 `alu_sll`: `f = a << b[4:0]`.
- 010 `alu_sra`: `f = $signed(a) >>> b[4:0]`; sign bit replicated.
- 011 `alu_sub`: `f = a - b`, modulo 2^32.
- 100 `alu_xor`: `f = a ^ b`.
- 101 `alu_srl`: `f = a >> b[4:0]`; zero fill.
- 110 `alu_or`: `f = a | b`.
- 111 `alu_and`: `f = a & b`.

Rules:
- `b[31:5]` is ignored for all shifts. A shift amount of 0 returns `a` unchanged.
- No flags, no overflow detection, no traps.
- `f` is fully defined for every `aluop` value; there is no X output and no latch.
- If `aluop` carries X/Z in simulation, `f` is driven to all-zero.

## Timing
- `f` is purely combinational from `aluop`, `a` and `b`, with zero-cycle latency. It must settle within one clock period, alongside the upstream forwarding muxes.
- `f_q`:
  - Asynchronously cleared to 0 while `rst_n` is low.
  - On each rising edge with `rst_n` high and `en` high, `f_q <= f`.
  - With `en` low, `f_q` holds its value.
  - Latency from inputs to `f_q` is 1 cycle.
- Reset asserted mid-operation clears `f_q` immediately, without waiting for a clock edge. `f` is unaffected by reset and keeps tracking its inputs.
- On reset release, the first edge with `en` high loads `f`.
- There is no handshake; every cycle is independent.

## Structure
- The `alu_ops` enum (3-bit, encoding above) lives in the shared `rv32i_types` package together with `rv32i_word`.
- The module contains one `always_comb` case over `aluop` and one `always_ff` block for `f_q`.
- No sub-modules are required. A barrel shifter may optionally be split out as `rv32i_shifter`, taking a direction and arithmetic select.

## Test plan
- Add/sub wrap: `add` with `a=0xFFFFFFFF`, `b=1` -> `f=0`. `sub` with `a=0`, `b=1` -> `f=0xFFFFFFFF`. `sub` with `a=5`, `b=3` -> `f=2`.
- Shifts:
  - `sll` with `a=1`, `b=31` -> `0x80000000`.
  - `srl` with `a=0x80000000`, `b=4` -> `0x08000000`.
  - `sra` with the same operands -> `0xF8000000`.
  - `sra` with `a=0x7FFFFFF0`, `b=4` -> `0x07FFFFFF`.
- Shift masking: `sll` with `a=1`, `b=0x00000021` -> `f=2` (only `b[4:0]=1` used). `srl` with `b=0` -> `f=a`.
- Logic ops with `a=0xF0F0F0F0`, `b=0xFF00FF00`:
  - `xor` -> `0x0FF00FF0`
  - `or` -> `0xFFF0FFF0`
  - `and` -> `0xF000F000`
- Register path:
  - Drive `rst_n` low -> `f_q=0` without a clock edge.
  - Release reset, `add` `a=2`, `b=3`, `en=1`, one edge -> `f_q=5`.
  - Set `en=0`, change inputs -> `f_q` stays 5.
  - Assert `rst_n` low mid-cycle -> `f_q=0` at once.
- Random sweep: 10k random `aluop`/`a`/`b` combinations checked against a reference model of the same equations. `f` must never be X.
